// File: rtl/evm_booth_scheduler.sv
// evm_booth_scheduler: serves NUM_BOOTHS booth consoles round-robin against one evm core.
// The FSM sequences switch_on / candidate_ready / vote / session_done toward the evm.
// Each booth gets exactly one ack or reject pulse per request.
module evm_booth_scheduler #(
  parameter int NUM_BOOTHS  = 4,
  parameter int WIDTH       = 7,
  parameter int BALLOT_CAP  = 127,
  parameter int VIP_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          session_start,
  input  logic                          session_stop,
  input  logic [NUM_BOOTHS-1:0]         booth_req,
  input  logic [2*NUM_BOOTHS-1:0]       booth_choice,
  output logic [NUM_BOOTHS-1:0]         booth_ack,
  output logic [NUM_BOOTHS-1:0]         booth_reject,
  output logic                          evm_switch_on,
  output logic                          evm_candidate_ready,
  output logic [2:0]                    evm_vote,
  output logic                          evm_session_done,
  input  logic                          evm_vip,
  input  logic                          evm_done,
  output logic [$clog2(NUM_BOOTHS)-1:0] grant_id,
  output logic [WIDTH-1:0]              ballots_cast,
  output logic                          session_open
);
  localparam int IW = $clog2(NUM_BOOTHS);
  localparam int TW = $clog2(VIP_TIMEOUT + 1);

  localparam logic [3:0] OFF      = 4'd0;
  localparam logic [3:0] WARM     = 4'd1;
  localparam logic [3:0] ARB      = 4'd2;
  localparam logic [3:0] READY    = 4'd3;
  localparam logic [3:0] WAIT_VIP = 4'd4;
  localparam logic [3:0] CAST     = 4'd5;
  localparam logic [3:0] SETTLE   = 4'd6;
  localparam logic [3:0] CLOSE    = 4'd7;
  localparam logic [3:0] DONE     = 4'd8;

  logic [3:0]                     state;
  logic [IW-1:0]                  rr;
  logic [1:0]                     choice_q;
  logic [TW-1:0]                  timer;
  logic                           warm_cnt;
  logic                           settle_seen;
  logic                           stop_q;
  logic                           restart_q;
  logic [NUM_BOOTHS-1:0][1:0]     ch_arr;
  logic [NUM_BOOTHS-1:0]          avail;
  logic                           pick_vld;
  logic [IW-1:0]                  pick_idx;
  logic [IW-1:0]                  j;
  logic                           in_session;

  assign ch_arr     = booth_choice;
  assign in_session = (state inside {ARB, READY, WAIT_VIP, CAST, SETTLE});

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (i == IW'(NUM_BOOTHS - 1)) ? '0 : i + 1'b1;
  endfunction

  // Round-robin pick: first requester at/after rr; a booth whose pulse is
  // on the wire this cycle is masked so a held request is not served twice.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = '0;
    avail    = booth_req & ~(booth_ack | booth_reject);
    for (int k = 0; k < NUM_BOOTHS; k++) begin
      j = IW'((int'(rr) + k) % NUM_BOOTHS);
      if (!pick_vld && avail[j]) begin
        pick_vld = 1'b1;
        pick_idx = j;
      end
    end
  end

  // evm-facing strobes are decoded from state so each lasts exactly one state visit.
  always_comb begin
    evm_switch_on       = (state != OFF);
    evm_candidate_ready = (state == READY);
    evm_session_done    = (state == CLOSE);
    session_open        = in_session;
    evm_vote            = 3'b000;
    if (state == CAST) begin
      case (choice_q)
        2'b01:   evm_vote = 3'b001;
        2'b10:   evm_vote = 3'b010;
        2'b11:   evm_vote = 3'b100;
        default: evm_vote = 3'b000;
      endcase
    end
  end

  // Main sequencer: state, rr pointer, ballot counter and ack/reject pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= OFF;
      rr           <= '0;
      grant_id     <= '0;
      choice_q     <= '0;
      timer        <= '0;
      warm_cnt     <= 1'b0;
      settle_seen  <= 1'b0;
      stop_q       <= 1'b0;
      restart_q    <= 1'b0;
      ballots_cast <= '0;
      booth_ack    <= '0;
      booth_reject <= '0;
    end else begin
      booth_ack    <= '0;
      booth_reject <= '0;
      if (in_session && session_stop) stop_q <= 1'b1;
      case (state)
        OFF: begin
          stop_q <= 1'b0;
          if (session_start || restart_q) begin
            state     <= WARM;
            warm_cnt  <= 1'b0;
            restart_q <= 1'b0;
          end
        end
        WARM: begin
          ballots_cast <= '0;
          if (warm_cnt) state <= ARB;
          else          warm_cnt <= 1'b1;
        end
        ARB: begin
          if (evm_done) begin
            state <= DONE;
          end else if (stop_q || session_stop || ballots_cast == WIDTH'(BALLOT_CAP)) begin
            state <= CLOSE;
          end else if (pick_vld) begin
            if (ch_arr[pick_idx] == 2'b00) begin
              booth_reject[pick_idx] <= 1'b1;
              rr                     <= nxt(pick_idx);
            end else begin
              grant_id <= pick_idx;
              choice_q <= ch_arr[pick_idx];
              state    <= READY;
            end
          end
        end
        READY: begin
          timer <= '0;
          state <= WAIT_VIP;
        end
        WAIT_VIP: begin
          if (evm_vip) begin
            state <= CAST;
          end else if (timer == TW'(VIP_TIMEOUT - 1)) begin
            booth_reject[grant_id] <= 1'b1;
            rr                     <= nxt(grant_id);
            state                  <= ARB;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CAST: begin
          settle_seen <= 1'b0;
          state       <= SETTLE;
        end
        SETTLE: begin
          if (evm_done) begin
            booth_reject[grant_id] <= 1'b1;
            rr                     <= nxt(grant_id);
            state                  <= DONE;
          end else if (!evm_vip) begin
            // one extra cycle after vip falls lets the evm commit its count
            if (settle_seen) begin
              booth_ack[grant_id] <= 1'b1;
              rr                  <= nxt(grant_id);
              if (ballots_cast != WIDTH'(BALLOT_CAP)) ballots_cast <= ballots_cast + 1'b1;
              state <= ARB;
            end else begin
              settle_seen <= 1'b1;
            end
          end
        end
        CLOSE: begin
          if (evm_done) state <= DONE;
        end
        DONE: begin
          if (session_start) begin
            // pass through OFF for one cycle so the evm clears, then warm up again
            state     <= OFF;
            restart_q <= 1'b1;
            stop_q    <= 1'b0;
          end else if (pick_vld) begin
            booth_reject[pick_idx] <= 1'b1;
            rr                     <= nxt(pick_idx);
          end
        end
        default: state <= OFF;
      endcase
    end
  end
endmodule
